// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if
// Groups everything between the two transaction sequencers, the arbiter and
// the shared I2C byte engine.
//   requester side : req0/req1, gnt0/gnt1, per-requester start/send/receive/
//                    datasend in, sended/received/datareceive out
//   engine side    : start (active low)/send/receive/datasend out,
//                    sended/received/datareceive in
//   status         : busy, timeout_err, timeout_id
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding sequencers and engine.
interface i2c_bus_arbiter_if;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       start0, start1;
  logic       send0, send1;
  logic       receive0, receive1;
  logic [7:0] datasend0, datasend1;
  logic       sended0, sended1;
  logic       received0, received1;
  logic [7:0] datareceive0, datareceive1;
  logic       start, send, receive;
  logic [7:0] datasend;
  logic       sended, received;
  logic [7:0] datareceive;
  logic       busy, timeout_err, timeout_id;

  modport slave (
    input  req0, req1, start0, start1, send0, send1, receive0, receive1,
           datasend0, datasend1, sended, received, datareceive,
    output gnt0, gnt1, sended0, sended1, received0, received1,
           datareceive0, datareceive1, start, send, receive, datasend,
           busy, timeout_err, timeout_id
  );

  modport master (
    output req0, req1, start0, start1, send0, send1, receive0, receive1,
           datasend0, datasend1, sended, received, datareceive,
    input  gnt0, gnt1, sended0, sended1, received0, received1,
           datareceive0, datareceive1, start, send, receive, datasend,
           busy, timeout_err, timeout_id
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Shares one I2C byte engine between two transaction sequencers.
// Arbitration is round-robin, and grants are registered. The owner is muxed
// onto the engine while the other requester is isolated. After each release
// the engine is held idle for IDLE_GAP cycles. A watchdog aborts an owner
// that makes no sended/received progress for TIMEOUT cycles.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : i2c_bus_arbiter_if.slave (requesters, engine, status)
module i2c_bus_arbiter #(
  parameter int unsigned IDLE_GAP = 4,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  i2c_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [7:0]  GAP_LAST = 8'(IDLE_GAP - 32'd1);
  localparam logic [15:0] WD_LAST  = TIMEOUT - 16'd1;

  state_t      state_r, state_s;
  logic        last_r, last_s;
  logic        armed0_r, armed1_r, armed0_s, armed1_s;
  logic        gnt0_r, gnt1_r, busy_r;
  logic        timeout_err_r, timeout_err_s;
  logic        timeout_id_r, timeout_id_s;
  logic        sended_q_r, received_q_r;
  logic        progress_s;
  logic        elig0_s, elig1_s;
  logic [15:0] wd_r;
  logic [7:0]  gap_r;
  logic        start_s, send_s, receive_s;
  logic [7:0]  datasend_s;
  logic        sended0_s, sended1_s, received0_s, received1_s;
  logic [7:0]  datareceive0_s, datareceive1_s;

  // Progress means a rising edge on either engine completion flag.
  assign progress_s = (bus.sended & ~sended_q_r) | (bus.received & ~received_q_r);
  assign elig0_s    = bus.req0 & armed0_r;
  assign elig1_s    = bus.req1 & armed1_r;

  // Next-state logic: arbitration, release, and watchdog abort.
  always_comb begin
    state_s       = state_r;
    last_s        = last_r;
    timeout_err_s = 1'b0;
    timeout_id_s  = timeout_id_r;
    // A dropped request always re-arms its requester.
    armed0_s      = armed0_r | ~bus.req0;
    armed1_s      = armed1_r | ~bus.req1;
    case (state_r)
      IDLE: begin
        if (elig0_s && elig1_s) begin
          state_s = last_r ? OWN0 : OWN1;
        end else if (elig0_s) begin
          state_s = OWN0;
        end else if (elig1_s) begin
          state_s = OWN1;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0: begin
        // A release takes priority over a watchdog expiry in the same cycle.
        if (!bus.req0) begin
          state_s = GAP;
          last_s  = 1'b0;
        end else if ((wd_r == WD_LAST) && !progress_s) begin
          state_s       = GAP;
          last_s        = 1'b0;
          timeout_err_s = 1'b1;
          timeout_id_s  = 1'b0;
          armed0_s      = 1'b0;
        end else begin
          state_s = OWN0;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_s = GAP;
          last_s  = 1'b1;
        end else if ((wd_r == WD_LAST) && !progress_s) begin
          state_s       = GAP;
          last_s        = 1'b1;
          timeout_err_s = 1'b1;
          timeout_id_s  = 1'b1;
          armed1_s      = 1'b0;
        end else begin
          state_s = OWN1;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Engine and requester muxing. The outputs are decoded from the state
  // register only, so a reset forces them idle without waiting for a clock.
  always_comb begin
    start_s        = 1'b1;
    send_s         = 1'b0;
    receive_s      = 1'b0;
    datasend_s     = 8'h00;
    sended0_s      = 1'b0;
    sended1_s      = 1'b0;
    received0_s    = 1'b0;
    received1_s    = 1'b0;
    datareceive0_s = 8'h00;
    datareceive1_s = 8'h00;
    case (state_r)
      OWN0: begin
        start_s        = bus.start0;
        send_s         = bus.send0;
        receive_s      = bus.receive0;
        datasend_s     = bus.datasend0;
        sended0_s      = bus.sended;
        received0_s    = bus.received;
        datareceive0_s = bus.datareceive;
      end
      OWN1: begin
        start_s        = bus.start1;
        send_s         = bus.send1;
        receive_s      = bus.receive1;
        datasend_s     = bus.datasend1;
        sended1_s      = bus.sended;
        received1_s    = bus.received;
        datareceive1_s = bus.datareceive;
      end
      default: begin
        start_s = 1'b1;
      end
    endcase
  end

  // State, arbitration history, and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      last_r        <= 1'b1;
      armed0_r      <= 1'b1;
      armed1_r      <= 1'b1;
      gnt0_r        <= 1'b0;
      gnt1_r        <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      timeout_id_r  <= 1'b0;
      sended_q_r    <= 1'b0;
      received_q_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      last_r        <= last_s;
      armed0_r      <= armed0_s;
      armed1_r      <= armed1_s;
      gnt0_r        <= (state_s == OWN0);
      gnt1_r        <= (state_s == OWN1);
      busy_r        <= (state_s != IDLE);
      timeout_err_r <= timeout_err_s;
      timeout_id_r  <= timeout_id_s;
      sended_q_r    <= bus.sended;
      received_q_r  <= bus.received;
    end
  end

  // Watchdog counts owned cycles without progress and restarts on every state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= 16'd0;
    end else if (((state_r == OWN0) || (state_r == OWN1)) && (state_s == state_r) && !progress_s) begin
      wd_r <= wd_r + 16'd1;
    end else begin
      wd_r <= 16'd0;
    end
  end

  // Gap counter counts the cycles spent in GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_r <= 8'd0;
    end else if ((state_r == GAP) && (state_s == GAP)) begin
      gap_r <= gap_r + 8'd1;
    end else begin
      gap_r <= 8'd0;
    end
  end

  assign bus.gnt0         = gnt0_r;
  assign bus.gnt1         = gnt1_r;
  assign bus.busy         = busy_r;
  assign bus.timeout_err  = timeout_err_r;
  assign bus.timeout_id   = timeout_id_r;
  assign bus.start        = start_s;
  assign bus.send         = send_s;
  assign bus.receive      = receive_s;
  assign bus.datasend     = datasend_s;
  assign bus.sended0      = sended0_s;
  assign bus.sended1      = sended1_s;
  assign bus.received0    = received0_s;
  assign bus.received1    = received1_s;
  assign bus.datareceive0 = datareceive0_s;
  assign bus.datareceive1 = datareceive1_s;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter. It uses a cycle-by-cycle vector table for
// ownership and muxing, plus directed sequences for alternation, lone
// re-grant, the watchdog, and asynchronous reset. The DUT runs with
// TIMEOUT=16 and IDLE_GAP=4.
module tb_i2c_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  i2c_bus_arbiter_if bus ();

  i2c_bus_arbiter #(.IDLE_GAP(4), .TIMEOUT(16'd16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req0, req1;
    logic [2:0]  c0;      // {start0, send0, receive0}
    logic [7:0]  ds0;
    logic [2:0]  c1;      // {start1, send1, receive1}
    logic [7:0]  ds1;
    logic        sended, received;
    logic [7:0]  dr;
    logic [33:0] exp;
  } vec_t;

  vec_t tbl[13];

  // Expected-output packer: {gnt0,gnt1,busy,{start,send,receive},datasend,
  // {sended0,sended1,received0,received1},datareceive0,datareceive1}
  function automatic logic [33:0] ex(input logic g0, input logic g1, input logic bsy,
                                     input logic [2:0] eng, input logic [7:0] ds,
                                     input logic [3:0] rt, input logic [7:0] dr0,
                                     input logic [7:0] dr1);
    return {g0, g1, bsy, eng, ds, rt, dr0, dr1};
  endfunction

  function automatic logic [33:0] observed();
    return {bus.gnt0, bus.gnt1, bus.busy, bus.start, bus.send, bus.receive, bus.datasend,
            bus.sended0, bus.sended1, bus.received0, bus.received1,
            bus.datareceive0, bus.datareceive1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.start0 = 1'b1; bus.send0 = 1'b0; bus.receive0 = 1'b0; bus.datasend0 = 8'h00;
    bus.start1 = 1'b1; bus.send1 = 1'b0; bus.receive1 = 1'b0; bus.datasend1 = 8'h00;
    bus.sended = 1'b0; bus.received = 1'b0; bus.datareceive = 8'h00;
  endtask

  task automatic apply(input vec_t v);
    bus.req0 = v.req0;
    bus.req1 = v.req1;
    {bus.start0, bus.send0, bus.receive0} = v.c0;
    bus.datasend0 = v.ds0;
    {bus.start1, bus.send1, bus.receive1} = v.c1;
    bus.datasend1 = v.ds1;
    bus.sended = v.sended;
    bus.received = v.received;
    bus.datareceive = v.dr;
  endtask

  // Waits (bounded) for any grant; returns the grant pair and ticks used.
  task automatic wait_grant(output logic g0, output logic g1, output int n);
    n = 0;
    while (!(bus.gnt0 || bus.gnt1) && n < 40) begin
      tick();
      n++;
    end
    g0 = bus.gnt0;
    g1 = bus.gnt1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    check("wait_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic g0, g1;
    logic [1:0] e2;
    int n, errs, lost;

    tbl[0]  = '{1'b0, 1'b0, 3'b100, 8'h00, 3'b100, 8'h00, 1'b0, 1'b0, 8'h00,
                ex(1'b0, 1'b0, 1'b0, 3'b100, 8'h00, 4'b0000, 8'h00, 8'h00)};
    tbl[1]  = '{1'b1, 1'b0, 3'b010, 8'hA5, 3'b100, 8'h00, 1'b0, 1'b0, 8'h00,
                ex(1'b0, 1'b0, 1'b0, 3'b100, 8'h00, 4'b0000, 8'h00, 8'h00)};
    tbl[2]  = '{1'b1, 1'b0, 3'b010, 8'hA5, 3'b100, 8'h00, 1'b1, 1'b0, 8'h3C,
                ex(1'b1, 1'b0, 1'b1, 3'b010, 8'hA5, 4'b1000, 8'h3C, 8'h00)};
    tbl[3]  = '{1'b1, 1'b1, 3'b101, 8'hA5, 3'b011, 8'h77, 1'b0, 1'b1, 8'h5A,
                ex(1'b1, 1'b0, 1'b1, 3'b101, 8'hA5, 4'b0010, 8'h5A, 8'h00)};
    tbl[4]  = '{1'b0, 1'b1, 3'b100, 8'h00, 3'b011, 8'h77, 1'b1, 1'b0, 8'h5A,
                ex(1'b1, 1'b0, 1'b1, 3'b100, 8'h00, 4'b1000, 8'h5A, 8'h00)};
    for (int i = 5; i <= 8; i++) begin
      tbl[i] = '{1'b0, 1'b1, 3'b010, 8'hFF, 3'b011, 8'h77, 1'b1, 1'b0, 8'h5A,
                 ex(1'b0, 1'b0, 1'b1, 3'b100, 8'h00, 4'b0000, 8'h00, 8'h00)};
    end
    tbl[9]  = '{1'b0, 1'b1, 3'b100, 8'h00, 3'b011, 8'h77, 1'b0, 1'b0, 8'h5A,
                ex(1'b0, 1'b0, 1'b0, 3'b100, 8'h00, 4'b0000, 8'h00, 8'h00)};
    tbl[10] = '{1'b0, 1'b1, 3'b100, 8'h00, 3'b011, 8'h77, 1'b0, 1'b1, 8'hC3,
                ex(1'b0, 1'b1, 1'b1, 3'b011, 8'h77, 4'b0001, 8'h00, 8'hC3)};
    tbl[11] = '{1'b0, 1'b0, 3'b100, 8'h00, 3'b100, 8'h00, 1'b0, 1'b0, 8'hC3,
                ex(1'b0, 1'b1, 1'b1, 3'b100, 8'h00, 4'b0000, 8'h00, 8'hC3)};
    tbl[12] = '{1'b0, 1'b0, 3'b100, 8'h00, 3'b100, 8'h00, 1'b0, 1'b0, 8'hC3,
                ex(1'b0, 1'b0, 1'b1, 3'b100, 8'h00, 4'b0000, 8'h00, 8'h00)};

    // Reset state, checked before any clock edge.
    idle_inputs();
    bus.sended = 1'b1;
    bus.datareceive = 8'h99;
    reset = 1'b0;
    #2;
    check("reset_state",
          {bus.gnt0, bus.gnt1, bus.busy, bus.timeout_err, bus.timeout_id, bus.start, bus.send,
           bus.receive, bus.datasend, bus.sended0, bus.sended1, bus.received0, bus.received1,
           bus.datareceive0, bus.datareceive1},
          {5'b00000, 3'b100, 8'h00, 4'b0000, 16'h0000});
    idle_inputs();
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Cycle-by-cycle ownership and mux table.
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      #1;
      check($sformatf("row%0d", i), observed(), tbl[i].exp);
      tick();
    end
    idle_inputs();
    wait_idle();

    // Alternation from reset, with minimum turnaround.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g0, g1, n);
      e2 = (k % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("alt%0d", k), {g0, g1}, e2);
      if (k > 0) check($sformatf("turn%0d", k), 1 + n, 6);
      repeat (3) tick();
      if (g0) bus.req0 = 1'b0;
      else bus.req1 = 1'b0;
      tick();
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();

    // A lone requester is regranted even though it owned the bus last.
    bus.req1 = 1'b1;
    wait_grant(g0, g1, n);
    check("lone_first", {g0, g1}, 2'b01);
    tick();
    bus.req1 = 1'b0;
    tick();
    wait_idle();
    bus.req1 = 1'b1;
    wait_grant(g0, g1, n);
    check("lone_again", {g0, g1}, 2'b01);
    bus.req1 = 1'b0;
    tick();
    wait_idle();

    // Watchdog abort of requester 0 while requester 1 is pending.
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_grant(g0, g1, n);
    check("to_grant", {g0, g1}, 2'b10);
    repeat (15) tick();
    check("to_before", {bus.gnt0, bus.timeout_err}, 2'b10);
    tick();
    check("to_pulse", {bus.gnt0, bus.gnt1, bus.timeout_err, bus.timeout_id, bus.busy}, 5'b00101);
    tick();
    check("to_once", {63'd0, bus.timeout_err}, 64'd0);
    wait_grant(g0, g1, n);
    check("to_pending", {g0, g1, bus.timeout_id}, 3'b010);
    bus.req1 = 1'b0;
    repeat (12) tick();
    check("to_locked", {bus.gnt0, bus.busy}, 2'b00);
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1;
    wait_grant(g0, g1, n);
    check("to_rearm", {g0, g1}, 2'b10);
    bus.req0 = 1'b0;
    tick();
    wait_idle();

    // Watchdog abort of requester 1 sets timeout_id.
    bus.req1 = 1'b1;
    wait_grant(g0, g1, n);
    repeat (16) tick();
    check("to_id1", {bus.gnt1, bus.timeout_err, bus.timeout_id}, 3'b011);
    bus.req1 = 1'b0;
    tick();
    wait_idle();

    // Periodic progress keeps the watchdog from expiring.
    bus.req0 = 1'b1;
    wait_grant(g0, g1, n);
    errs = 0;
    lost = 0;
    for (int i = 0; i < 200; i++) begin
      bus.sended = (i % 10 == 0);
      tick();
      if (bus.timeout_err) errs++;
      if (!bus.gnt0) lost++;
    end
    check("wd_no_err", errs, 0);
    check("wd_kept_grant", lost, 0);
    bus.sended = 1'b0;
    bus.req0 = 1'b0;
    tick();
    wait_idle();

    // Asynchronous reset in the middle of an OWN1 transaction.
    bus.req1 = 1'b1;
    wait_grant(g0, g1, n);
    bus.start1 = 1'b0;
    bus.send1 = 1'b1;
    #1;
    check("own1_mux", {g1, bus.start, bus.send}, 3'b101);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", {bus.start, bus.send, bus.receive, bus.gnt1, bus.busy}, 5'b10000);
    bus.req0 = 1'b1;
    #3;
    reset = 1'b1;
    wait_grant(g0, g1, n);
    check("rst_prio", {g0, g1}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C byte engine between two transaction sequencers, e.g. the BMP180 sequencer and a second sensor sequencer.
- Byte-engine handshake: active-low start, send/sended, receive/received/datareceive.
- Each requester holds req for a whole transaction. The arbiter grants round-robin, muxes the granted requester onto the engine, isolates the other requester, enforces an idle gap between owners, and aborts a stalled owner by watchdog.

Parameters:
IDLE_GAP, 4, cycles the engine is held idle (start=1, send=0, receive=0) after a release, before the next grant.
TIMEOUT, 16'hFFFF, cycles without a sended/received rising edge during a grant before forced release.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants the bus; held high for the whole transaction
req1  input  1  requester 1 wants the bus
gnt0  output  1  requester 0 owns the engine
gnt1  output  1  requester 1 owns the engine
start0, start1  input  1 each  per-requester active-low start
send0, send1  input  1 each  per-requester send
receive0, receive1  input  1 each  per-requester receive
datasend0, datasend1  input  8 each  per-requester byte to transmit
sended0, sended1  output  1 each  engine sended, routed to the owner only
received0, received1  output  1 each  engine received, routed to the owner only
datareceive0, datareceive1  output  8 each  engine datareceive, routed to the owner only
start  output  1  to engine, active low
send  output  1  to engine
receive  output  1  to engine
datasend  output  8  to engine
sended  input  1  from engine
received  input  1  from engine
datareceive  input  8  from engine
busy  output  1  high in any state except IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort
timeout_id  output  1  requester aborted by the last timeout; holds its value until the next timeout

Behaviour:
- Reset (asynchronous, active low), from any state including mid-transaction:
  - state=IDLE, gnt0=gnt1=0, busy=0, timeout_err=0, timeout_id=0, last=1 (so requester 0 wins first), watchdog=0, gap counter=0, armed0=armed1=1.
  - Engine outputs go immediately to start=1, send=0, receive=0, datasend=8'h00.
  - sendedN/receivedN=0 and datareceiveN=8'h00 for both requesters.
- States: IDLE, OWN0, OWN1, GAP.
- IDLE:
  - Eligible requester: reqN=1 and armedN=1.
  - One eligible: go to OWNN next cycle.
  - Both eligible: choose the one not equal to last.
  - gnt is registered: it rises exactly 1 cycle after req is sampled high in IDLE.
- OWNN:
  - gntN=1, busy=1.
  - Engine start/send/receive/datasend follow requester N combinationally.
  - sendedN/receivedN/datareceiveN follow the engine; the other requester's copies are forced to 0.
  - Watchdog clears on any rising edge of sended or received (edge via registered copies) and otherwise increments.
  - reqN=0 sampled: set last=N, go to GAP; gntN falls the next cycle.
  - Watchdog == TIMEOUT-1 with reqN still 1:
    - pulse timeout_err one cycle, timeout_id=N, armedN=0, last=N, go to GAP.
    - Requester N is not re-eligible until reqN is sampled 0 (armedN then returns to 1).
  - A request from the other requester during OWNN is held pending; it is never preempted.
- GAP:
  - gnt0=gnt1=0, busy=1; engine forced idle (start=1, send=0, receive=0, datasend=0).
  - Counts IDLE_GAP cycles, then goes to IDLE.
  - Arbitration happens only in IDLE. Minimum bus turnaround is IDLE_GAP+2 cycles from owner req fall to the next gnt rise.
- armedN also re-sets whenever reqN=0 in any state.
- Counter widths: watchdog 16 bit, gap counter 8 bit, both saturating-free (reset on state entry).
- Simultaneous events:
  - req drop and watchdog expiry in the same cycle: treated as a normal release, no timeout_err.
  - Engine sended/received edge in the same cycle as release: still routed to the owner that cycle; ignored afterwards.

Test Plan:
- Only req0 raised at cycle 10, held 50 cycles -> gnt0 rises at cycle 11; engine start mirrors start0; sended1/received1 stay 0; after req0 falls, gnt0 falls 1 cycle later and busy stays high for IDLE_GAP=4 cycles.
- req0 and req1 raised together from reset -> requester 0 granted first; after release and gap, requester 1 is granted without deasserting req1; repeat -> alternates 0,1,0,1.
- req1 alone, released, then raised again with req0 idle -> requester 1 regranted after the gap (round-robin does not block a lone requester).
- TIMEOUT=16, req0 held with no sended/received edges -> timeout_err pulses at the 16th owned cycle, timeout_id=0, gnt0 drops; req0 is not regranted until it falls and rises again; pending req1 is granted after the gap.
- Periodic sended pulses every 10 cycles with TIMEOUT=16 -> no timeout over 200 cycles.
- Reset asserted mid-OWN1 with send1=1 -> start=1, send=0, gnt1=0 with no clock edge; after release, IDLE with requester 0 priority.
